serial_comp_digit: RTL
======================

// Module: serial_comp_digit
// PURPOSE
// - Digit-serial magnitude comparator; successor to the 1-bit serial comparator FSM.
// - Takes A and B LSB-first, DIGIT_W bits per accepted cycle; a word is WORD_DIGITS digits.
// - Adds: valid-qualified input, per-word unsigned/signed mode, word framing and a held final result.
// - Sits between serial links and control logic that needs A>B / A==B / A<B per word.
// PARAMETERS
// - DIGIT_W      1  bits per digit (>=1); word width = DIGIT_W*WORD_DIGITS
// - WORD_DIGITS  8  digits per word (>=1)
// PORTS
// - clk          in   1        clock; all state changes on rising edge
// - reset_n      in   1        asynchronous, active-low reset
// - clear        in   1        synchronous abort of the current word
// - in_valid     in   1        a/b/signed_mode valid this cycle (digit accepted)
// - a            in   DIGIT_W  digit of A, LSB-first order
// - b            in   DIGIT_W  digit of B, LSB-first order
// - signed_mode  in   1        1 = two's-complement word; sampled on digit 0 only
// - greater      out  1        running result, A>B so far (registered, Moore)
// - equal        out  1        running result, A==B so far
// - less         out  1        running result, A<B so far
// - done         out  1        1-cycle pulse: final result loaded
// - res_greater  out  1        final A>B of last complete word (held)
// - res_equal    out  1        final A==B of last complete word (held)
// - res_less     out  1        final A<B of last complete word (held)
// - digit_cnt    out  clog2(WORD_DIGITS) (min 1)  index of next digit expected
// BEHAVIOUR
// - Reset (reset_n=0, async): state=EQUAL, equal=1, greater=less=0; res_equal=1,
//   res_greater=res_less=0; done=0, digit_cnt=0, signed register=0.
// - FSM states (encoding): EQUAL 3'b001, GREATER 3'b010, LESS 3'b011; outputs decode state, exactly one high.
// - Accepted digit (in_valid=1, clear=0), not last: a>b -> GREATER; a<b -> LESS; a==b -> hold state.
//   Digit compare unsigned. Later digit is more significant, so it overrides earlier ones.
// - Last digit (digit_cnt==WORD_DIGITS-1): compare signed if word is signed, else unsigned.
//   Equal digit: final = current state. Differing digit: final = GREATER or LESS.
//   Next edge: res_* <= final; done <= 1; state <= EQUAL; digit_cnt <= 0.
// - Latency: running outputs reflect a digit 1 cycle after acceptance.
//   done/res_* update 1 cycle after last digit. done is high otherwise 0.
// - signed_mode is latched when digit 0 is accepted. It is ignored on other digits.
//   WORD_DIGITS=1: that digit's signed_mode is used directly.
// - in_valid=0: everything holds except done, which returns to 0.
// - Back-to-back words: digit 0 of the next word may be accepted in the cycle right after the last digit.
// - clear=1: state=EQUAL, digit_cnt=0, done=0 next edge; res_* unchanged. Concurrent digit is dropped.
// - reset_n mid-word: word discarded, all outputs to reset values; res_* also reset.
// - digit_cnt wraps WORD_DIGITS-1 -> 0 only on an accepted last digit.
// TESTING (DIGIT_W=4, WORD_DIGITS=2; digits listed LSB first as (a,b))
// - Unsigned A=0x3A, B=0x2F: (A,F) then (3,2), valid back-to-back.
//   -> less after cycle 1; done pulse with res_greater=1; running equal=1 after.
// - Signed A=0x80 (-128), B=0x01: (0,1), (8,0), signed_mode=1 on digit 0 -> res_less=1.
//   Same digits with signed_mode=0 -> res_greater=1.
// - A=B=0x55 with in_valid gaps of 0..3 cycles -> equal held throughout.
//   Outputs frozen on gaps; res_equal=1; exactly one done pulse.
// - Two back-to-back words 0x10 vs 0x01 then 0x01 vs 0x10: done on consecutive words.
//   -> res_greater then res_less; digit_cnt 0,1,0,1.
// - clear after digit 0 of word (F,0) -> state EQUAL, digit_cnt=0, res_* unchanged, no done.
//   Then reset_n low mid-word -> all reset values immediately (async).

Source files
------------

// File: rtl/serial_comp_digit.sv
// Digit-serial magnitude comparator: A and B arrive LSB-first, DIGIT_W bits per accepted
// cycle, and a word of WORD_DIGITS digits yields a held final greater/equal/less result.
module serial_comp_digit #(
    parameter int DIGIT_W     = 1,
    parameter int WORD_DIGITS = 8,
    localparam int CNT_W      = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               signed_mode,
    output logic               greater,
    output logic               equal,
    output logic               less,
    output logic               done,
    output logic               res_greater,
    output logic               res_equal,
    output logic               res_less,
    output logic [CNT_W-1:0]   digit_cnt
);

    typedef enum logic [2:0] {
        EQUAL   = 3'b001,
        GREATER = 3'b010,
        LESS    = 3'b011
    } state_t;

    state_t             state_q, state_d;
    state_t             res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sgn_q, sgn_d;
    logic               done_q, done_d;
    logic               last, word_signed, dig_gt, dig_lt;

    assign last = (cnt_q == CNT_W'(WORD_DIGITS - 1));

    // A one-digit word has no earlier digit to latch the mode from.
    assign word_signed = (WORD_DIGITS == 1) ? signed_mode : sgn_q;

    // Only the most significant digit carries the sign.
    always_comb begin
        if (last && word_signed) begin
            dig_gt = $signed(a) > $signed(b);
            dig_lt = $signed(a) < $signed(b);
        end else begin
            dig_gt = a > b;
            dig_lt = a < b;
        end
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        done_d  = 1'b0;
        if (clear) begin
            state_d = EQUAL;
            cnt_d   = '0;
        end else if (in_valid) begin
            if (cnt_q == '0)
                sgn_d = signed_mode;
            if (last) begin
                if (dig_gt)      res_d = GREATER;
                else if (dig_lt) res_d = LESS;
                else             res_d = state_q;
                state_d = EQUAL;
                cnt_d   = '0;
                done_d  = 1'b1;
            end else begin
                if (dig_gt)      state_d = GREATER;
                else if (dig_lt) state_d = LESS;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= EQUAL;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_q  <= EQUAL;
            cnt_q  <= '0;
            sgn_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            res_q  <= res_d;
            cnt_q  <= cnt_d;
            sgn_q  <= sgn_d;
            done_q <= done_d;
        end
    end

    assign greater     = (state_q == GREATER);
    assign equal       = (state_q == EQUAL);
    assign less        = (state_q == LESS);
    assign res_greater = (res_q == GREATER);
    assign res_equal   = (res_q == EQUAL);
    assign res_less    = (res_q == LESS);
    assign done        = done_q;
    assign digit_cnt   = cnt_q;

endmodule
